// File: rtl/cnt_pattern_checker.sv
// Receive-side checker for the 8-bit incrementing dummy-data stream: hunts, acquires and holds lock.
// Optional build macro CHK_ERR_CAPTURE_EN adds EXP_Q/GOT_Q capture of the first locked-state mismatch.
module cnt_pattern_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             CLK,
  input  logic             nCLR,
  input  logic             nEN,
  input  logic [7:0]       D,
  input  logic             nRESYNC,
  output logic             LOCKED,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [1:0]       STATE
`ifdef CHK_ERR_CAPTURE_EN
  ,
  output logic [7:0]       EXP_Q,
  output logic [7:0]       GOT_Q
`endif
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_BAD    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  ref_q, ref_d;
  logic [CNT_W-1:0]   match_q, match_d;
  logic [CNT_W-1:0]   miss_q, miss_d;
  logic               err_q, err_d;
  logic               locked_q;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic [DATA_W-1:0]  exp_val_c;
  logic               hit_c;
  logic               sample_c;
  logic               lock_miss_c;
  logic [CNT_W-1:0]   match_inc_c;
  logic [CNT_W-1:0]   miss_inc_c;

  // A sample counts only when enabled and not pre-empted by a resync on the same edge.
  assign exp_val_c   = DATA_W'(ref_q + DATA_W'(1));
  assign hit_c       = (D == exp_val_c);
  assign sample_c    = nRESYNC && !nEN;
  assign lock_miss_c = sample_c && (state_q == ST_LOCKED) && !hit_c;
  assign match_inc_c = CNT_W'(match_q + CNT_W'(1));
  assign miss_inc_c  = CNT_W'(miss_q + CNT_W'(1));

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (!nRESYNC) begin
      state_d = ST_HUNT;
      ref_d   = '0;
      match_d = '0;
      miss_d  = '0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (!nEN) begin
            ref_d   = D;
            match_d = CNT_W'(1);
            state_d = ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (!nEN) begin
            ref_d = D;
            if (hit_c) begin
              match_d = match_inc_c;
              if (match_inc_c == CNT_W'(LOCK_CNT)) begin
                state_d = ST_LOCKED;
                miss_d  = '0;
              end
            end else begin
              match_d = CNT_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (!nEN) begin
            ref_d = D;
            if (hit_c) begin
              miss_d = '0;
            end else begin
              err_d  = 1'b1;
              miss_d = miss_inc_c;
              if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = ERR_W'(err_cnt_q + ERR_W'(1));
              end
              if (miss_inc_c == CNT_W'(LOSS_CNT)) begin
                state_d = ST_HUNT;
                miss_d  = '0;
              end
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          ref_d   = '0;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state_q   <= ST_HUNT;
      ref_q     <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      err_q     <= err_d;
      locked_q  <= (state_d == ST_LOCKED);
      err_cnt_q <= err_cnt_d;
    end
  end

  assign LOCKED  = locked_q;
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;
  assign STATE   = state_q;

`ifdef CHK_ERR_CAPTURE_EN
  logic              cap_done_q;
  logic [DATA_W-1:0] exp_q, got_q;

  // First locked-state mismatch after reset is frozen until the next nCLR.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      cap_done_q <= 1'b0;
      exp_q      <= '0;
      got_q      <= '0;
    end else if (lock_miss_c && !cap_done_q) begin
      cap_done_q <= 1'b1;
      exp_q      <= exp_val_c;
      got_q      <= D;
    end
  end

  assign EXP_Q = exp_q;
  assign GOT_Q = got_q;
`endif

endmodule

// File: tb/tb_cnt_pattern_checker.sv
// Scoreboard bench for cnt_pattern_checker: a default instance and an ERR_W=4 instance share stimulus.
module tb_cnt_pattern_checker;

  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned LOSS_CNT = 3;

  logic        CLK = 1'b0;
  logic        nCLR, nEN, nRESYNC;
  logic [7:0]  D;
  logic        LOCKED, ERR, LOCKED4, ERR4;
  logic [15:0] ERR_CNT;
  logic [3:0]  ERR_CNT4;
  logic [1:0]  STATE, STATE4;
`ifdef CHK_ERR_CAPTURE_EN
  logic [7:0]  EXP_Q, GOT_Q, EXP_Q4, GOT_Q4;
`endif

  always #5 CLK = ~CLK;

  cnt_pattern_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(16)) dut (
    .CLK(CLK), .nCLR(nCLR), .nEN(nEN), .D(D), .nRESYNC(nRESYNC),
    .LOCKED(LOCKED), .ERR(ERR), .ERR_CNT(ERR_CNT), .STATE(STATE)
`ifdef CHK_ERR_CAPTURE_EN
    , .EXP_Q(EXP_Q), .GOT_Q(GOT_Q)
`endif
  );

  cnt_pattern_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(4)) dut4 (
    .CLK(CLK), .nCLR(nCLR), .nEN(nEN), .D(D), .nRESYNC(nRESYNC),
    .LOCKED(LOCKED4), .ERR(ERR4), .ERR_CNT(ERR_CNT4), .STATE(STATE4)
`ifdef CHK_ERR_CAPTURE_EN
    , .EXP_Q(EXP_Q4), .GOT_Q(GOT_Q4)
`endif
  );

  typedef struct {
    logic [1:0]  st;
    logic        err;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic [7:0]  ex;
    logic [7:0]  gt;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  // Reference model state
  int         m_state, m_match, m_miss, m_cnt16, m_cnt4;
  logic [7:0] m_ref, m_exp, m_got;
  logic       m_err, m_cap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_match = 0; m_miss = 0; m_cnt16 = 0; m_cnt4 = 0;
    m_ref = 8'h00; m_exp = 8'h00; m_got = 8'h00; m_err = 1'b0; m_cap = 1'b0;
  endtask

  task automatic model(input logic nen, input logic [7:0] d, input logic nrs);
    logic [7:0] nxt;
    nxt   = m_ref + 8'd1;
    m_err = 1'b0;
    if (!nrs) begin
      m_state = 0; m_ref = 8'h00; m_match = 0; m_miss = 0;
    end else if (!nen) begin
      if (m_state == 0) begin
        m_match = 1; m_state = 1;
      end else if (m_state == 1) begin
        if (d == nxt) begin
          m_match = m_match + 1;
          if (m_match == LOCK_CNT) begin m_state = 2; m_miss = 0; end
        end else begin
          m_match = 1;
        end
      end else begin
        if (d == nxt) begin
          m_miss = 0;
        end else begin
          m_err = 1'b1;
          if (m_cnt16 < 65535) m_cnt16 = m_cnt16 + 1;
          if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
          if (!m_cap) begin m_cap = 1'b1; m_exp = nxt; m_got = d; end
          m_miss = m_miss + 1;
          if (m_miss == LOSS_CNT) begin m_state = 0; m_miss = 0; end
        end
      end
      m_ref = d;
    end
  endtask

  // Drive one cycle; expected outputs queued at drive time, popped after the edge.
  task automatic step(input logic nen, input logic [7:0] d, input logic nrs);
    exp_t e;
    @(negedge CLK);
    nEN = nen; D = d; nRESYNC = nrs;
    model(nen, d, nrs);
    e.st = 2'(m_state); e.err = m_err; e.cnt = 16'(m_cnt16); e.cnt4 = 4'(m_cnt4);
    e.ex = m_exp; e.gt = m_got;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    chk("state", 32'(STATE), 32'(e.st));
    chk("locked", 32'(LOCKED), 32'(e.st == 2'd2));
    chk("err", 32'(ERR), 32'(e.err));
    chk("err_cnt", 32'(ERR_CNT), 32'(e.cnt));
    chk("err_cnt_w4", 32'(ERR_CNT4), 32'(e.cnt4));
    chk("state_w4", 32'(STATE4), 32'(e.st));
`ifdef CHK_ERR_CAPTURE_EN
    chk("exp_q", 32'(EXP_Q), 32'(e.ex));
    chk("got_q", 32'(GOT_Q), 32'(e.gt));
`endif
    if (ERR) err_pulses++;
    nEN = 1'b1; nRESYNC = 1'b1;
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic pulse_reset();
    @(posedge CLK);
    #2;
    nCLR = 1'b0;
    #1;
    chk("rst_async_state", 32'(STATE), 32'd0);
    chk("rst_async_locked", 32'(LOCKED), 32'd0);
    chk("rst_async_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("rst_async_err", 32'(ERR), 32'd0);
`ifdef CHK_ERR_CAPTURE_EN
    chk("rst_async_exp_q", 32'(EXP_Q), 32'd0);
    chk("rst_async_got_q", 32'(GOT_Q), 32'd0);
`endif
    #1;
    nCLR = 1'b1;
    model_reset();
  endtask

  initial begin
    nCLR = 1'b0; nEN = 1'b1; D = 8'h00; nRESYNC = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", 32'(STATE), 32'd0);
    chk("reset_locked", 32'(LOCKED), 32'd0);
    chk("reset_err", 32'(ERR), 32'd0);
    chk("reset_err_cnt", 32'(ERR_CNT), 32'd0);
    #2;
    nCLR = 1'b1;

    // Lock on 00..03, then run through the 8-bit wrap up to 0x0F
    for (int i = 0; i < 4; i++) step(1'b0, 8'(i), 1'b1);
    chk("t1_locked", 32'(LOCKED), 32'd1);
    chk("t1_state", 32'(STATE), 32'd2);
    for (int i = 4; i < 256 + 16; i++) step(1'b0, 8'(i), 1'b1);
    chk("t1_no_err", 32'(err_pulses), 32'd0);
    chk("t1_err_cnt", 32'(ERR_CNT), 32'd0);

    // Single jump gives exactly one error
    err_pulses = 0;
    step(1'b0, 8'h10, 1'b1); step(1'b0, 8'h11, 1'b1);
    step(1'b0, 8'h20, 1'b1); step(1'b0, 8'h21, 1'b1); step(1'b0, 8'h22, 1'b1);
    chk("t2_pulses", 32'(err_pulses), 32'd1);
    chk("t2_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("t2_locked", 32'(LOCKED), 32'd1);

    // Three misses drop lock, then relock without touching the count
    err_pulses = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h50, 1'b1);
    chk("t3_pulses", 32'(err_pulses), 32'd3);
    chk("t3_err_cnt", 32'(ERR_CNT), 32'd4);
    chk("t3_locked", 32'(LOCKED), 32'd0);
    chk("t3_state", 32'(STATE), 32'd0);
    for (int i = 8'h60; i <= 8'h63; i++) step(1'b0, 8'(i), 1'b1);
    chk("t3_relock", 32'(LOCKED), 32'd1);
    chk("t3_err_cnt_held", 32'(ERR_CNT), 32'd4);

    // Gaps are transparent
    for (int i = 8'h64; i <= 256 + 7; i++) step(1'b0, 8'(i), 1'b1);
    err_pulses = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'hAA, 1'b1);
    step(1'b0, 8'h08, 1'b1);
    chk("t4_gap_no_err", 32'(err_pulses), 32'd0);
    chk("t4_gap_locked", 32'(LOCKED), 32'd1);

    // ACQ mismatch restarts acquisition silently
    pulse_reset();
    err_pulses = 0;
    step(1'b0, 8'h00, 1'b1); step(1'b0, 8'h01, 1'b1); step(1'b0, 8'h05, 1'b1);
    step(1'b0, 8'h06, 1'b1); step(1'b0, 8'h07, 1'b1);
    chk("t4_acq_not_yet", 32'(LOCKED), 32'd0);
    step(1'b0, 8'h08, 1'b1);
    chk("t4_acq_no_err", 32'(err_pulses), 32'd0);
    chk("t4_acq_locked", 32'(LOCKED), 32'd1);

    // Resync beats a same-edge sample and keeps ERR_CNT
    step(1'b0, 8'h30, 1'b1);
    step(1'b0, 8'h09, 1'b0);
    chk("t5_resync_state", 32'(STATE), 32'd0);
    chk("t5_resync_cnt", 32'(ERR_CNT), 32'd1);
    step(1'b1, 8'h0A, 1'b1);
    chk("t5_resync_idle", 32'(STATE), 32'd0);

    // 21 locked mismatches: the 4-bit counter saturates
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 4; k++) step(1'b0, 8'(8'h40 + r * 16 + k), 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, 8'(8'h40 + r * 16 + 3), 1'b1);
    end
    chk("t5_sat_w4", 32'(ERR_CNT4), 32'd15);
    chk("t5_cnt_w16", 32'(ERR_CNT), 32'd22);

    // Async reset while locked
    for (int i = 8'h70; i <= 8'h73; i++) step(1'b0, 8'(i), 1'b1);
    chk("t6_locked_before", 32'(LOCKED), 32'd1);
    pulse_reset();

    // First-mismatch capture held across later errors and resync
    for (int i = 8'h0E; i <= 8'h11; i++) step(1'b0, 8'(i), 1'b1);
    step(1'b0, 8'h40, 1'b1);
    step(1'b0, 8'h99, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("t6_cap_cnt", 32'(ERR_CNT), 32'd2);
`ifdef CHK_ERR_CAPTURE_EN
    chk("t6_exp_q", 32'(EXP_Q), 32'h12);
    chk("t6_got_q", 32'(GOT_Q), 32'h40);
`endif
    pulse_reset();
    step(1'b1, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
